// File: rtl/seq_det_pkg.sv
// seq_det_pkg: defaults and elaboration-time helpers for the serial pattern detector.
package seq_det_pkg;
  localparam int DEF_PAT_LEN = 4;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1010;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  // Longest pattern prefix that is a suffix of (first k pattern bits, then b); pattern MSB arrives first.
  function automatic int next_state(input int k, input logic b, input logic [15:0] pat, input int len);
    int r;
    int i;
    logic ok;
    logic sb;
    r = 0;
    for (int j = 1; j <= len && j <= k + 1; j++) begin
      ok = 1'b1;
      for (int m = 0; m < j; m++) begin
        i = k + 1 - j + m;
        sb = (i < k) ? pat[4'(len - 1 - i)] : b;
        if (pat[4'(len - 1 - m)] != sb) ok = 1'b0;
      end
      if (ok) r = j;
    end
    return r;
  endfunction
endpackage

// File: rtl/seq1010_moore_detector.sv
// seq1010_moore_detector: overlapping Moore detector for a serial PATTERN, MSB first.
module seq1010_moore_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
  input  logic clk,
  input  logic areset,
  input  logic in,
  output logic out
);
  localparam int SW = clog2(PAT_LEN + 1);
  typedef logic [SW-1:0] state_t;
  localparam state_t S0 = '0;
  localparam state_t S_LAST = SW'(PAT_LEN);
  state_t state_q, state_d;
  state_t nxt0 [PAT_LEN+1];
  state_t nxt1 [PAT_LEN+1];
  // State k = length of longest received suffix that is a pattern prefix.
  for (genvar s = 0; s <= PAT_LEN; s++) begin : g_tbl
    assign nxt0[s] = SW'(next_state(s, 1'b0, 16'(PATTERN), PAT_LEN));
    assign nxt1[s] = SW'(next_state(s, 1'b1, 16'(PATTERN), PAT_LEN));
  end
  always_ff @(posedge clk or negedge areset)
    if (!areset) state_q <= S0;
    else state_q <= state_d;
  always_comb begin
    state_d = S0;
    if (state_q <= S_LAST) state_d = in ? nxt1[state_q] : nxt0[state_q];
  end
  assign out = (state_q == S_LAST);
endmodule

// File: tb/tb_seq1010_moore_detector.sv
// tb_seq1010_moore_detector: directed table-driven checks for default (1010) and 110 detectors.
module tb_seq1010_moore_detector;
  logic clk = 1'b0;
  logic areset = 1'b0;
  logic din = 1'b0;
  logic din2 = 1'b0;
  logic dout, dout2;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {logic b; logic o; int s;} vec_t;
  vec_t vt [22];
  seq1010_moore_detector dut (.clk(clk), .areset(areset), .in(din), .out(dout));
  seq1010_moore_detector #(.PAT_LEN(3), .PATTERN(3'b110)) dut2 (.clk(clk), .areset(areset), .in(din2), .out(dout2));
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask
  task automatic tick(input logic b, input logic b2);
    @(negedge clk);
    din = b;
    din2 = b2;
    @(posedge clk);
    #1;
  endtask
  task automatic chk1(input string name, input logic o, input int s);
    check({name, " out"}, int'(dout), int'(o));
    check({name, " state"}, int'(dut.state_q), s);
  endtask
  task automatic chk2(input string name, input logic o, input int s);
    check({name, " out2"}, int'(dout2), int'(o));
    check({name, " state2"}, int'(dut2.state_q), s);
  endtask
  initial begin
    vt = '{
      '{1'b0, 1'b0, 0}, '{1'b1, 1'b0, 1}, '{1'b0, 1'b0, 2}, '{1'b1, 1'b0, 3}, '{1'b0, 1'b1, 4}, '{1'b0, 1'b0, 0},
      '{1'b1, 1'b0, 1}, '{1'b0, 1'b0, 2}, '{1'b1, 1'b0, 3}, '{1'b0, 1'b1, 4}, '{1'b1, 1'b0, 3}, '{1'b0, 1'b1, 4},
      '{1'b0, 1'b0, 0},
      '{1'b1, 1'b0, 1}, '{1'b1, 1'b0, 1}, '{1'b0, 1'b0, 2}, '{1'b0, 1'b0, 0}, '{1'b1, 1'b0, 1}, '{1'b0, 1'b0, 2},
      '{1'b0, 1'b0, 0}, '{1'b1, 1'b0, 1}, '{1'b1, 1'b0, 1}
    };
    tick(1'b1, 1'b1);
    chk1("rst_hold0", 1'b0, 0);
    chk2("rst_hold0", 1'b0, 0);
    tick(1'b0, 1'b1);
    chk1("rst_hold1", 1'b0, 0);
    chk2("rst_hold1", 1'b0, 0);
    @(negedge clk);
    areset = 1'b1;
    din2 = 1'b0;
    foreach (vt[i]) begin
      tick(vt[i].b, 1'b0);
      chk1($sformatf("vec%0d", i), vt[i].o, vt[i].s);
    end
    chk2("idle2", 1'b0, 0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk1("drain", 1'b0, 0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk1("mid_pre", 1'b0, 3);
    #2 areset = 1'b0;
    #1 chk1("mid_async", 1'b0, 0);
    tick(1'b0, 1'b0);
    chk1("mid_held", 1'b0, 0);
    @(negedge clk);
    areset = 1'b1;
    tick(1'b0, 1'b0);
    chk1("mid_after", 1'b0, 0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk1("restart_hit", 1'b1, 4);
    #2 areset = 1'b0;
    #1 chk1("hit_async_clr", 1'b0, 0);
    @(negedge clk);
    areset = 1'b1;
    din = 1'b0;
    tick(1'b0, 1'b1);
    chk2("p110_a1", 1'b0, 1);
    tick(1'b0, 1'b1);
    chk2("p110_a2", 1'b0, 2);
    tick(1'b0, 1'b1);
    chk2("p110_a3", 1'b0, 2);
    tick(1'b0, 1'b0);
    chk2("p110_a4", 1'b1, 3);
    tick(1'b0, 1'b0);
    chk2("p110_gap", 1'b0, 0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk2("p110_b1", 1'b1, 3);
    tick(1'b0, 1'b1);
    chk2("p110_b2", 1'b0, 1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk2("p110_b3", 1'b1, 3);
    chk1("dut1_quiet", 1'b0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
